// File: rtl/mips_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_loader_if
// Description : Bundle of the loader's host-load, byte-memory, core-control
//               and dump-stream signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_mem_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              mem_sel;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              core_reset;
    logic              core_hold;
    logic              dump_req;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              done;

    // The loader itself
    modport master (
        input  ld_valid, ld_addr, ld_data, ld_last, mem_rdata, dump_req, dump_ready,
        output ld_ready, mem_sel, mem_we, mem_addr, mem_wdata,
               core_reset, core_hold, dump_valid, dump_addr, dump_data, done
    );

    // Host, memory and consumer side
    modport slave (
        output ld_valid, ld_addr, ld_data, ld_last, mem_rdata, dump_req, dump_ready,
        input  ld_ready, mem_sel, mem_we, mem_addr, mem_wdata,
               core_reset, core_hold, dump_valid, dump_addr, dump_data, done
    );
endinterface
`default_nettype wire

// File: rtl/mips_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_loader
// Description : Streams (address, word) pairs into the core's byte-wide
//               memory as little-endian bytes while the core is in reset,
//               runs the core for a bounded time, then freezes it and reads
//               a strided window of words out on a valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_loader #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                RUN_CYCLES  = 42,
    parameter logic [ADDR_W-1:0] DUMP_BASE   = ADDR_W'(32'h1001_0000),
    parameter logic [ADDR_W-1:0] DUMP_STRIDE = ADDR_W'(32'h20),
    parameter int                DUMP_COUNT  = 3
) (
    input  wire logic         CLK,
    input  wire logic         reset,
    mips_mem_loader_if.master bus
);
    localparam int          c_BYTES    = DATA_W / 8;
    localparam int          c_KW       = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_BYTES - 1);
    localparam logic [31:0] c_RUN_LAST = (RUN_CYCLES == 0) ? 32'd0 : 32'(RUN_CYCLES - 1);
    localparam logic [31:0] c_DCNT_LAST = (DUMP_COUNT == 0) ? 32'd0 : 32'(DUMP_COUNT - 1);
    localparam bit          c_TIMED    = (RUN_CYCLES != 0);
    localparam bit          c_NO_DUMP  = (DUMP_COUNT == 0);

    typedef enum logic [2:0] {
        S_LOAD     = 3'd0,
        S_WRITE    = 3'd1,
        S_RUN      = 3'd2,
        S_DUMP_RD  = 3'd3,
        S_DUMP_OUT = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [c_KW-1:0]   r_k;
    logic [31:0]       r_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_word;
    logic [31:0]       r_dcnt;
    logic [7:0]        w_wbyte;
    logic              w_run_exit;
    logic              w_k_last;

    assign w_k_last   = (r_k == c_K_LAST);
    // Terminal count and an early request coinciding collapse into one exit
    assign w_run_exit = (c_TIMED && (r_cnt == c_RUN_LAST)) || bus.dump_req;

    assign bus.dump_addr = r_ptr;
    assign bus.dump_data = r_word;

    // Select the byte of the latched load word addressed by the byte index
    always_comb begin
        w_wbyte = 8'h00;
        for (int b = 0; b < c_BYTES; b++) begin
            if (r_k == c_KW'(b)) begin
                w_wbyte = r_data[b*8 +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next         = r_state;
        bus.ld_ready   = 1'b0;
        bus.mem_sel    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = 8'h00;
        bus.core_reset = 1'b0;
        bus.core_hold  = 1'b0;
        bus.dump_valid = 1'b0;
        bus.done       = 1'b0;
        case (r_state)
            S_LOAD: begin
                bus.ld_ready   = 1'b1;
                bus.core_reset = 1'b1;
                if (bus.ld_valid) w_next = S_WRITE;
            end
            S_WRITE: begin
                bus.core_reset = 1'b1;
                bus.mem_sel    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = r_addr + ADDR_W'(r_k);
                bus.mem_wdata  = w_wbyte;
                if (w_k_last) w_next = r_last ? S_RUN : S_LOAD;
            end
            S_RUN: begin
                if (w_run_exit) w_next = c_NO_DUMP ? S_DONE : S_DUMP_RD;
            end
            S_DUMP_RD: begin
                bus.core_hold = 1'b1;
                bus.mem_sel   = 1'b1;
                bus.mem_addr  = r_ptr + ADDR_W'(r_k);
                if (w_k_last) w_next = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                bus.core_hold  = 1'b1;
                bus.dump_valid = 1'b1;
                if (bus.dump_ready) w_next = (r_dcnt == c_DCNT_LAST) ? S_DONE : S_DUMP_RD;
            end
            S_DONE: begin
                bus.core_hold = 1'b1;
                bus.done      = 1'b1;
            end
            default: w_next = S_LOAD;
        endcase
    end

    // Datapath: load latch, byte index, run counter, dump pointer and word
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_data <= '0;
            r_last <= 1'b0;
            r_k    <= '0;
            r_cnt  <= '0;
            r_ptr  <= '0;
            r_word <= '0;
            r_dcnt <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        r_addr <= bus.ld_addr;
                        r_data <= bus.ld_data;
                        r_last <= bus.ld_last;
                        r_k    <= '0;
                    end
                end
                S_WRITE: begin
                    r_k   <= w_k_last ? '0 : r_k + c_KW'(1);
                    r_cnt <= '0;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_run_exit) begin
                        r_ptr  <= DUMP_BASE;
                        r_k    <= '0;
                        r_dcnt <= '0;
                    end
                end
                S_DUMP_RD: begin
                    for (int b = 0; b < c_BYTES; b++) begin
                        if (r_k == c_KW'(b)) r_word[b*8 +: 8] <= bus.mem_rdata;
                    end
                    r_k <= w_k_last ? '0 : r_k + c_KW'(1);
                end
                S_DUMP_OUT: begin
                    if (bus.dump_ready) begin
                        r_ptr  <= r_ptr + DUMP_STRIDE;
                        r_dcnt <= r_dcnt + 32'd1;
                        r_k    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mem_loader
// Description : Self-checking bench for mips_mem_loader (default instance plus
//               a RUN_CYCLES=0 instance for request-driven dumps).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem_loader;
    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam logic [31:0] STRIDE = 32'h20;
    localparam int          DCNT   = 3;

    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
        logic [31:0] ea [4];
        logic [7:0]  eb [4];
    } ld_vec_t;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    logic reset1 = 1'b0;
    always #5 CLK = ~CLK;

    mips_mem_loader_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mips_mem_loader_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mips_mem_loader dut0 (.CLK(CLK), .reset(reset), .bus(bus0));
    mips_mem_loader #(.RUN_CYCLES(0), .DUMP_COUNT(1)) dut1 (.CLK(CLK), .reset(reset1), .bus(bus1));

    logic [7:0] m0 [logic [31:0]];
    logic [7:0] m1 [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    wr_t wlog [$];
    wr_t exp_w [$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    function automatic logic [7:0] rd0(input logic [31:0] a);
        return m0.exists(a) ? m0[a] : 8'h00;
    endfunction
    function automatic logic [7:0] rd1(input logic [31:0] a);
        return m1.exists(a) ? m1[a] : 8'h00;
    endfunction
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++)
            w[b*8 +: 8] = ref_mem.exists(a + 32'(b)) ? ref_mem[a + 32'(b)] : 8'h00;
        return w;
    endfunction

    assign bus0.mem_rdata = rd0(bus0.mem_addr);
    assign bus1.mem_rdata = rd1(bus1.mem_addr);

    always @(posedge CLK) cyc <= cyc + 1;

    // Byte writes are captured mid-cycle, when the strobe is settled
    initial forever begin
        @(negedge CLK);
        if (bus0.mem_sel && bus0.mem_we) begin
            m0[bus0.mem_addr] = bus0.mem_wdata;
            wlog.push_back('{a: bus0.mem_addr, d: bus0.mem_wdata});
        end
        if (bus1.mem_sel && bus1.mem_we) m1[bus1.mem_addr] = bus1.mem_wdata;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference memory model: little-endian byte placement with address wrap
    task automatic model_load(input logic [31:0] a, input logic [31:0] d, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            ref_mem[a + 32'(b)] = d[b*8 +: 8];
            exp_w.push_back('{a: a + 32'(b), d: d[b*8 +: 8]});
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            m0[a + 32'(b)] = d[b*8 +: 8];
            ref_mem[a + 32'(b)] = d[b*8 +: 8];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_ready"}, bus0.ld_ready, 1);
        check({tag, "_core_reset"}, bus0.core_reset, 1);
        check({tag, "_core_hold"}, bus0.core_hold, 0);
        check({tag, "_mem_sel"}, bus0.mem_sel, 0);
        check({tag, "_mem_we"}, bus0.mem_we, 0);
        check({tag, "_mem_addr"}, bus0.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus0.mem_wdata, 0);
        check({tag, "_dump_addr"}, bus0.dump_addr, 0);
        check({tag, "_dump_data"}, bus0.dump_data, 0);
        check({tag, "_dump_valid"}, bus0.dump_valid, 0);
        check({tag, "_done"}, bus0.done, 0);
    endtask

    task automatic reset0(input string tag);
        bus0.ld_valid = 1'b0;
        bus0.dump_ready = 1'b0;
        bus0.dump_req = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        tick();
        tick();
        reset = 1'b0;
        wlog.delete();
        exp_w.delete();
    endtask

    // Offer one load word; returns at #1 after the accepting edge
    task automatic load_word(input logic [31:0] a, input logic [31:0] d, input bit last,
                             input int gap, input bit hold, output int acc_cyc);
        logic rdy;
        int t;
        bus0.ld_addr = a;
        bus0.ld_data = d;
        bus0.ld_last = last;
        if (gap > 0) begin
            bus0.ld_valid = 1'b0;
            repeat (gap) tick();
        end
        bus0.ld_valid = 1'b1;
        t = 0;
        do begin
            rdy = bus0.ld_ready;
            tick();
            t++;
        end while (!rdy && t < 50);
        if (!rdy) check("accept_timeout", 0, 1);
        acc_cyc = cyc;
        if (!hold) bus0.ld_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wcount"}, wlog.size(), exp_w.size());
        for (int i = 0; i < wlog.size() && i < exp_w.size(); i++) begin
            check({tag, "_waddr"}, wlog[i].a, exp_w[i].a);
            check({tag, "_wdata"}, wlog[i].d, exp_w[i].d);
        end
        wlog.delete();
        exp_w.delete();
    endtask

    task automatic wait_dump_start(input string tag, input int rel);
        int t = 0;
        while (!bus0.core_hold && t < 300) begin
            tick();
            t++;
        end
        check({tag, "_hold_seen"}, bus0.core_hold, 1);
        check({tag, "_run_len"}, cyc - rel, 42);
    endtask

    task automatic dump_words(input string tag, input int stall_idx, input bit rnd);
        for (int i = 0; i < DCNT; i++) begin
            logic [31:0] ea;
            logic [31:0] ew;
            int t;
            ea = BASE + STRIDE * 32'(i);
            ew = ref_word(ea);
            t = 0;
            while (!bus0.dump_valid && t < 50) begin
                tick();
                t++;
            end
            check({tag, "_dvalid"}, bus0.dump_valid, 1);
            check({tag, "_daddr"}, bus0.dump_addr, ea);
            check({tag, "_ddata"}, bus0.dump_data, ew);
            if (i == stall_idx) begin
                for (int s = 0; s < 10; s++) begin
                    tick();
                    check({tag, "_stall_valid"}, bus0.dump_valid, 1);
                    check({tag, "_stall_data"}, bus0.dump_data, ew);
                    check({tag, "_stall_addr"}, bus0.dump_addr, ea);
                end
            end else if (rnd) begin
                repeat ($urandom_range(0, 3)) tick();
            end
            bus0.dump_ready = 1'b1;
            tick();
            bus0.dump_ready = 1'b0;
            check({tag, "_vdrop"}, bus0.dump_valid, 0);
        end
        check({tag, "_done"}, bus0.done, 1);
        check({tag, "_done_hold"}, bus0.core_hold, 1);
        check({tag, "_done_sel"}, bus0.mem_sel, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_vec_t vecs [3];
        logic [7:0] b1st [4];
        logic [31:0] w1;
        int acc;
        int accs [3];
        int rel;
        int t;

        vecs[0].addr = 32'h0040_0000; vecs[0].data = 32'h2008_000A; vecs[0].last = 1'b0;
        vecs[0].ea = '{32'h0040_0000, 32'h0040_0001, 32'h0040_0002, 32'h0040_0003};
        vecs[0].eb = '{8'h0A, 8'h00, 8'h08, 8'h20};
        vecs[1].addr = 32'h0040_0004; vecs[1].data = 32'h2109_0014; vecs[1].last = 1'b0;
        vecs[1].ea = '{32'h0040_0004, 32'h0040_0005, 32'h0040_0006, 32'h0040_0007};
        vecs[1].eb = '{8'h14, 8'h00, 8'h09, 8'h21};
        vecs[2].addr = 32'hFFFF_FFFE; vecs[2].data = 32'hDEAD_BEEF; vecs[2].last = 1'b1;
        vecs[2].ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[2].eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        b1st = '{8'h0A, 8'h00, 8'h08, 8'h20};

        bus0.ld_valid = 0; bus0.ld_addr = 0; bus0.ld_data = 0; bus0.ld_last = 0;
        bus0.dump_req = 0; bus0.dump_ready = 0;
        bus1.ld_valid = 0; bus1.ld_addr = 0; bus1.ld_data = 0; bus1.ld_last = 0;
        bus1.dump_req = 0; bus1.dump_ready = 0;
        preload(32'h1001_0000, 32'h1122_3344);
        preload(32'h1001_0020, 32'h5566_7788);
        preload(32'h1001_0040, 32'h99AA_BBCC);

        // Single-word program, cycle-by-cycle write check, timed run, stalled dump
        reset0("rst_a");
        load_word(32'h0040_0000, 32'h2008_000A, 1'b1, 0, 1'b0, acc);
        model_load(32'h0040_0000, 32'h2008_000A, 4);
        for (int k = 0; k < 4; k++) begin
            check("a_mem_we", bus0.mem_we, 1);
            check("a_mem_sel", bus0.mem_sel, 1);
            check("a_mem_addr", bus0.mem_addr, 32'h0040_0000 + 32'(k));
            check("a_mem_wdata", bus0.mem_wdata, b1st[k]);
            check("a_core_reset_w", bus0.core_reset, 1);
            check("a_ld_ready_w", bus0.ld_ready, 0);
            tick();
        end
        check("a_mem_we_off", bus0.mem_we, 0);
        check("a_core_release", bus0.core_reset, 0);
        check("a_hold_run", bus0.core_hold, 0);
        rel = cyc;
        check_writes("a");
        wait_dump_start("a", rel);
        check("a_rd_sel", bus0.mem_sel, 1);
        check("a_rd_we", bus0.mem_we, 0);
        dump_words("a", 1, 1'b0);

        // Table-driven back-to-back load with address wrap
        reset0("rst_b");
        bus0.dump_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_word(vecs[i].addr, vecs[i].data, vecs[i].last, 0, 1'b1, accs[i]);
            model_load(vecs[i].addr, vecs[i].data, 4);
            if (i > 0) check("b_accept_spacing", accs[i] - accs[i-1], 5);
            if (i < 2) check("b_core_reset_load", bus0.core_reset, 1);
        end
        bus0.ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("b_core_reset_last", bus0.core_reset, 1);
            tick();
        end
        bus0.dump_req = 1'b0;
        check("b_core_release", bus0.core_reset, 0);
        rel = cyc;
        check("b_table_count", wlog.size(), 12);
        for (int i = 0; i < 3; i++)
            for (int b = 0; b < 4; b++)
                if (4*i + b < wlog.size()) begin
                    check("b_table_addr", wlog[4*i+b].a, vecs[i].ea[b]);
                    check("b_table_byte", wlog[4*i+b].d, vecs[i].eb[b]);
                end
        check_writes("b");
        wait_dump_start("b", rel);
        dump_words("b", -1, 1'b0);

        // Asynchronous reset during the second byte of a write
        reset0("rst_c");
        load_word(32'h0040_0100, 32'hCAFE_F00D, 1'b1, 0, 1'b0, acc);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("c_abort_we", bus0.mem_we, 0);
        check("c_abort_core_reset", bus0.core_reset, 1);
        check("c_abort_ld_ready", bus0.ld_ready, 1);
        check("c_abort_sel", bus0.mem_sel, 0);
        check("c_abort_addr", bus0.mem_addr, 0);
        model_load(32'h0040_0100, 32'hCAFE_F00D, 1);
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        check_writes("c_abort");
        load_word(32'h0040_0100, 32'h1357_2468, 1'b1, 1, 1'b0, acc);
        model_load(32'h0040_0100, 32'h1357_2468, 4);
        rel = acc + 4;
        repeat (4) tick();
        check_writes("c_fresh");
        wait_dump_start("c", rel);
        dump_words("c", -1, 1'b0);

        // Randomised programs, some overwriting the dump window
        for (int it = 0; it < 4; it++) begin
            int n;
            reset0("rst_r");
            n = $urandom_range(1, 4);
            for (int w = 0; w < n; w++) begin
                logic [31:0] a;
                logic [31:0] d;
                if ($urandom_range(0, 1) == 1) a = BASE + STRIDE * 32'($urandom_range(0, 2));
                else a = 32'h0040_0000 + 32'(4 * $urandom_range(0, 63));
                d = $urandom;
                load_word(a, d, (w == n - 1), $urandom_range(0, 3), 1'b0, acc);
                model_load(a, d, 4);
            end
            rel = acc + 4;
            repeat (4) tick();
            check_writes("r");
            wait_dump_start("r", rel);
            dump_words("r", -1, 1'b1);
        end

        // Request-driven dump on the RUN_CYCLES=0 instance
        w1 = $urandom;
        for (int b = 0; b < 4; b++) m1[BASE + 32'(b)] = w1[b*8 +: 8];
        reset1 = 1'b1;
        tick();
        tick();
        reset1 = 1'b0;
        bus1.dump_req = 1'b1;
        tick();
        bus1.dump_req = 1'b0;
        check("e_req_in_load_ready", bus1.ld_ready, 1);
        check("e_req_in_load_hold", bus1.core_hold, 0);
        bus1.ld_addr = 32'h0040_0000;
        bus1.ld_data = 32'h0000_0000;
        bus1.ld_last = 1'b1;
        bus1.ld_valid = 1'b1;
        tick();
        bus1.ld_valid = 1'b0;
        repeat (4) tick();
        check("e_release", bus1.core_reset, 0);
        repeat (6) tick();
        check("e_no_auto_exit", bus1.core_hold, 0);
        bus1.dump_req = 1'b1;
        tick();
        bus1.dump_req = 1'b0;
        check("e_req_hold", bus1.core_hold, 1);
        check("e_req_sel", bus1.mem_sel, 1);
        check("e_req_addr", bus1.mem_addr, BASE);
        t = 0;
        while (!bus1.dump_valid && t < 50) begin
            tick();
            t++;
        end
        check("e_dvalid", bus1.dump_valid, 1);
        check("e_daddr", bus1.dump_addr, BASE);
        check("e_ddata", bus1.dump_data, w1);
        bus1.dump_ready = 1'b1;
        tick();
        bus1.dump_ready = 1'b0;
        check("e_done", bus1.done, 1);
        bus1.dump_req = 1'b1;
        tick();
        bus1.dump_req = 1'b0;
        tick();
        check("e_req_in_done", bus1.done, 1);
        check("e_req_in_done_valid", bus1.dump_valid, 0);
        check("e_req_in_done_sel", bus1.mem_sel, 0);
        check("e_req_in_done_hold", bus1.core_hold, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
